// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int MDU_LAT_DEFAULT = 4;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID operand that depends on a load still in EXE.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_ADDR_W
) (
    input  logic             exe_mem_read,
    input  logic [REG_W-1:0] exe_dest,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    output logic             lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_use_rs && (id_rs == exe_dest);
    assign rt_hit = id_use_rt && (id_rt == exe_dest);

    // Register 0 is hardwired to zero, so a load targeting it creates no dependency.
    assign lu = exe_mem_read && (exe_dest != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller driving PC, IF/ID and ID/EXE enables, flushes and bubbles.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEFAULT,
    parameter int REG_W   = REG_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             exe_mem_read,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_mdu_op,
    input  logic             exe_redirect,
    output logic             pc_en,
    output logic             if2id_en,
    output logic             if2id_flush,
    output logic             id2exe_en,
    output logic             id2exe_bubble,
    output logic             mdu_done,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count,
`endif
    output logic             stall
);

    localparam int                CNT_W    = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MDU_LAT - 2);

    ctrl_state_t      state_reg;
    ctrl_state_t      state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             lu;

    load_use_detect #(
        .REG_W(REG_W)
    ) u_load_use_detect (
        .exe_mem_read(exe_mem_read),
        .exe_dest    (exe_dest),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .lu          (lu)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        if2id_en      = 1'b1;
        id2exe_en     = 1'b1;
        if2id_flush   = 1'b0;
        id2exe_bubble = 1'b0;
        mdu_done      = 1'b0;
        state_next    = state_reg;
        cnt_next      = cnt_reg;

        case (state_reg)
            RUN: begin
                if (exe_redirect) begin
                    // Wrong-path squash wins; a pending hazard belongs to a killed instruction.
                    if2id_flush   = 1'b1;
                    id2exe_bubble = 1'b1;
                end else if (exe_mdu_op) begin
                    pc_en      = 1'b0;
                    if2id_en   = 1'b0;
                    id2exe_en  = 1'b0;
                    cnt_next   = CNT_LOAD;
                    state_next = MDU_BUSY;
                end else if (lu) begin
                    pc_en         = 1'b0;
                    if2id_en      = 1'b0;
                    id2exe_bubble = 1'b1;
                end
            end
            MDU_BUSY: begin
                if (cnt_reg != '0) begin
                    pc_en     = 1'b0;
                    if2id_en  = 1'b0;
                    id2exe_en = 1'b0;
                    cnt_next  = cnt_reg - 1'b1;
                end else begin
                    mdu_done   = 1'b1;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase

        // Outputs are Mealy, so hold them at their idle values while reset is asserted.
        if (!rst) begin
            pc_en         = 1'b1;
            if2id_en      = 1'b1;
            id2exe_en     = 1'b1;
            if2id_flush   = 1'b0;
            id2exe_bubble = 1'b0;
            mdu_done      = 1'b0;
        end
    end

    assign stall = ~pc_en;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] flush_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (!pc_en && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (if2id_flush && (flush_count_reg != 32'hFFFF_FFFF)) begin
                flush_count_reg <= flush_count_reg + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (MDU_LAT=4), plus reset and counter sequences.
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             exe_mem_read;
    logic [REG_W-1:0] exe_dest;
    logic             exe_mdu_op;
    logic             exe_redirect;
    logic             pc_en;
    logic             if2id_en;
    logic             if2id_flush;
    logic             id2exe_en;
    logic             id2exe_bubble;
    logic             mdu_done;
    logic             stall;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(
        .MDU_LAT(4),
        .REG_W  (REG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .exe_mem_read (exe_mem_read),
        .exe_dest     (exe_dest),
        .exe_mdu_op   (exe_mdu_op),
        .exe_redirect (exe_redirect),
        .pc_en        (pc_en),
        .if2id_en     (if2id_en),
        .if2id_flush  (if2id_flush),
        .id2exe_en    (id2exe_en),
        .id2exe_bubble(id2exe_bubble),
        .mdu_done     (mdu_done),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
`endif
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             use_rs;
        logic             use_rt;
        logic             mem_read;
        logic [REG_W-1:0] dest;
        logic             mdu;
        logic             redir;
        logic [5:0]       exp;   // {pc_en, if2id_en, if2id_flush, id2exe_en, id2exe_bubble, mdu_done}
    } vec_t;

    localparam logic [5:0] E_IDLE  = 6'b110100;
    localparam logic [5:0] E_LU    = 6'b000110;
    localparam logic [5:0] E_HOLD  = 6'b000000;
    localparam logic [5:0] E_FLUSH = 6'b111110;
    localparam logic [5:0] E_DONE  = 6'b110101;

    vec_t vecs[$];

    function automatic vec_t mk(string n, int rs, int rt, bit urs, bit urt, bit mr, int dest,
                                bit mdu, bit redir, logic [5:0] exp);
        vec_t v;
        v.name = n; v.rs = REG_W'(rs); v.rt = REG_W'(rt); v.use_rs = urs; v.use_rt = urt;
        v.mem_read = mr; v.dest = REG_W'(dest); v.mdu = mdu; v.redir = redir; v.exp = exp;
        return v;
    endfunction

    task automatic drive(vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
        exe_mem_read = v.mem_read; exe_dest = v.dest; exe_mdu_op = v.mdu; exe_redirect = v.redir;
    endtask

    task automatic check_out(string n, logic [5:0] exp);
        logic [6:0] act;
        logic [6:0] req;
        act = {pc_en, if2id_en, if2id_flush, id2exe_en, id2exe_bubble, mdu_done, stall};
        req = {exp, ~exp[5]};
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: {pc,ifen,flush,iden,bub,done,stall} actual=%b required=%b", n, act, req);
        end else begin
            $display("ok   %s: outputs=%b", n, act);
        end
    endtask

    // One transaction: drive after the falling edge, sample 1 ns later, the rising edge follows.
    task automatic apply(vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check_out(v.name, v.exp);
    endtask

    initial begin
        vec_t idle;
        vec_t mdu_v;
        idle  = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
        mdu_v = mk("mdu", 0, 0, 0, 0, 0, 0, 1, 0, E_HOLD);

        vecs.push_back(mk("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
        vecs.push_back(mk("lu_rs",            5, 1, 1, 1, 1, 5, 0, 0, E_LU));
        vecs.push_back(mk("lu_cleared",       5, 1, 1, 1, 0, 5, 0, 0, E_IDLE));
        vecs.push_back(mk("zero_reg",         0, 0, 1, 1, 1, 0, 0, 0, E_IDLE));
        vecs.push_back(mk("rt_not_used",      1, 5, 1, 0, 1, 5, 0, 0, E_IDLE));
        vecs.push_back(mk("lu_rt",            2, 7, 1, 1, 1, 7, 0, 0, E_LU));
        vecs.push_back(mk("no_load_match",    7, 7, 1, 1, 0, 7, 0, 0, E_IDLE));
        vecs.push_back(mk("redirect_and_lu",  5, 0, 1, 0, 1, 5, 0, 1, E_FLUSH));
        vecs.push_back(mk("redirect_and_mdu", 0, 0, 0, 0, 0, 0, 1, 1, E_FLUSH));
        vecs.push_back(mk("run_after_redir",  0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
        vecs.push_back(mk("mdu_start",        0, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
        vecs.push_back(mk("mdu_busy1_redir",  3, 0, 1, 0, 1, 3, 1, 1, E_HOLD));
        vecs.push_back(mk("mdu_busy2_lu",     3, 0, 1, 0, 1, 3, 1, 0, E_HOLD));
        vecs.push_back(mk("mdu_done_redir",   0, 0, 0, 0, 0, 0, 1, 1, E_DONE));
        vecs.push_back(mk("b2b_mdu_start",    0, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
        vecs.push_back(mk("b2b_busy1",        0, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
        vecs.push_back(mk("b2b_busy2",        0, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
        vecs.push_back(mk("b2b_done",         0, 0, 0, 0, 0, 0, 1, 0, E_DONE));
        vecs.push_back(mk("run_lu_after_mdu", 4, 0, 1, 0, 1, 4, 0, 0, E_LU));
        vecs.push_back(mk("idle_end",         0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));

        // Reset asserted with a hazard pending on the inputs: outputs must still be idle.
        rst = 1'b0;
        drive(mk("rst_lu", 5, 0, 1, 0, 1, 5, 1, 0, E_IDLE));
        repeat (2) @(posedge clk);
        #1;
        check_out("in_reset", E_IDLE);
        @(negedge clk);
        drive(idle);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset during the second MDU cycle aborts the op; a new op runs the full sequence.
        apply(mk("rst_mdu_start", 0, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
        @(negedge clk);
        drive(mdu_v);
        #1;
        check_out("rst_mdu_busy1", E_HOLD);
        #2;
        rst = 1'b0;
        #1;
        check_out("rst_mid_busy", E_IDLE);
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        #1;
        check_out("rst_release_no_done", E_IDLE);
        apply(mk("restart_mdu",   0, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
        apply(mk("restart_busy1", 0, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
        apply(mk("restart_busy2", 0, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
        apply(mk("restart_done",  0, 0, 0, 0, 0, 0, 1, 0, E_DONE));
        apply(mk("restart_run",   0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));

`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset: stall_cycles=%0d flush_count=%0d required 0/0", stall_cycles, flush_count);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(mk("perf_lu", 5, 0, 1, 0, 1, 5, 0, 0, E_LU));
            apply(idle);
        end
        for (int k = 0; k < 2; k++) begin
            apply(mk("perf_redir", 0, 0, 0, 0, 0, 0, 0, 1, E_FLUSH));
            apply(idle);
        end
        checks++;
        if (stall_cycles !== 32'd3 || flush_count !== 32'd2) begin
            failures++;
            $display("FAIL perf_counts: stall_cycles=%0d flush_count=%0d required 3/2", stall_cycles, flush_count);
        end else begin
            $display("ok   perf_counts: stall_cycles=%0d flush_count=%0d", stall_cycles, flush_count);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage MIPS pipeline. It sequences the PC, the IF/ID register and the ID/EXE pipeline register. It detects load-use hazards, holds EXE for multi-cycle multiply/divide operations, and flushes wrong-path instructions when a branch or jump resolves taken in EXE. Its outputs are the only enable, flush and bubble sources for these three registers.

## Interface
- MDU_LAT, 4: number of cycles a multiply/divide occupies EXE; legal range ≥ 2
- REG_W, 5: register-address width
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- id_rs, id_rt  in  REG_W  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1  high when the ID instruction actually reads rs / rt
- exe_mem_read  in  1  the instruction in ID/EXE is a load
- exe_dest  in  REG_W  destination register of the instruction in ID/EXE
- exe_mdu_op  in  1  the instruction in ID/EXE is a multi-cycle MDU operation
- exe_redirect  in  1  a branch or jump resolved taken in EXE this cycle
- pc_en  out  1  PC write enable
- if2id_en  out  1  IF/ID write enable
- if2id_flush  out  1  IF/ID clears to NOP at the next edge
- id2exe_en  out  1  ID/EXE write enable; 0 holds the current contents
- id2exe_bubble  out  1  ID/EXE captures zeros (all controls 0) at the next edge
- mdu_done  out  1  one-cycle pulse in the final MDU cycle
- stall  out  1  equals ~pc_en

## Operation
- FSM has two states: RUN and MDU_BUSY. It also has a down-counter `cnt` of width clog2(MDU_LAT).
- All outputs are Mealy: they decode the current state and the current inputs, so a stall takes effect in the same cycle it is detected.
- Default outputs: pc_en=1, if2id_en=1, id2exe_en=1, if2id_flush=0, id2exe_bubble=0, mdu_done=0.
- Load-use hazard condition: `lu` = exe_mem_read & (exe_dest≠0) & ((id_use_rs & id_rs==exe_dest) | (id_use_rt & id_rt==exe_dest)).
- RUN state, evaluated in this priority order:
  - exe_redirect: if2id_flush=1, id2exe_bubble=1, pc_en=1. Stay in RUN. Any `lu` or exe_mdu_op in the same cycle is ignored.
  - exe_mdu_op: pc_en=0, if2id_en=0, id2exe_en=0. Load cnt=MDU_LAT-2 and go to MDU_BUSY.
  - lu: pc_en=0, if2id_en=0, id2exe_bubble=1. Stay in RUN. Exactly one bubble is inserted; in the next cycle the load has left EXE and forwarding resolves the operand.
- MDU_BUSY state:
  - When cnt≠0: pc_en=0, if2id_en=0, id2exe_en=0, and cnt decrements.
  - When cnt==0: mdu_done=1 and all enables are 1, so the stalled instruction advances. Go to RUN.
  - `lu` is not evaluated in MDU_BUSY, because EXE holds an MDU op, not a load.
  - exe_redirect is ignored in MDU_BUSY.
- id2exe_en=0 and id2exe_bubble=1 are never asserted together.
- Register 0 never causes a hazard.

## Timing
- Reset (rst=0), asynchronous: state=RUN, cnt=0. While rst is low, outputs are at their defaults: all enables 1, flush=0, bubble=0, mdu_done=0, stall=0.
- Reset mid-MDU_BUSY: the operation is aborted and no mdu_done is produced. A new exe_mdu_op after reset restarts the full MDU_LAT sequence.
- Load-use stall: 1 cycle. MDU: EXE occupied exactly MDU_LAT cycles, of which pc_en=0 for MDU_LAT-1. Redirect: 1 cycle with flush and bubble; no stall.
- Back-to-back MDU ops: the op arriving at the edge where mdu_done fires is detected in the next RUN cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments on each cycle with pc_en=0.
  - flush_count increments on each cycle with if2id_flush=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- HAZARD_PERF_CNT_EN undefined: these ports and counters do not exist.

## Structure
- pipe_ctrl_pkg holds the state enum (RUN, MDU_BUSY), REG_ADDR_W=5 and the MDU_LAT default.
- Sub-module load_use_detect is a combinational comparator producing `lu`. It is reused by forwarding debug logic.

## Test plan
- Load-use: exe_mem_read=1, exe_dest=5, id_rs=5, id_use_rs=1 → that cycle pc_en=0, if2id_en=0, id2exe_bubble=1. Next cycle with exe_mem_read=0 → all enables 1, bubble=0.
- Zero register: exe_mem_read=1, exe_dest=0, id_rs=0 → no stall. Also id_rt=5 matches exe_dest=5 with id_use_rt=0 → no stall.
- MDU with MDU_LAT=4 and exe_mdu_op held → pc_en and id2exe_en are 0 for 3 cycles. mdu_done=1 with all enables 1 in the 4th cycle. Next cycle is in RUN.
- Simultaneous exe_redirect=1 and lu=1 → if2id_flush=1, id2exe_bubble=1, pc_en=1, if2id_en=1.
- rst pulled low during the 2nd MDU_BUSY cycle → outputs immediately at defaults. After release, exe_mdu_op=1 gives a fresh 3-cycle stall followed by mdu_done.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls plus 2 redirects → stall_cycles=3, flush_count=2.
